mem_rr_arbiter: RTL and testbench

Round-robin memory arbiter that shares one memory channel among `NUM_CONSUMERS` load/store requesters in the GPU memory path. It sits between the per-thread LSUs and one memory port and uses the same request/ready handshake on both sides. Unlike a fixed-priority controller, it rotates the grant after every transaction, so no requester can starve.

---
 rtl/mem_rr_arbiter_if.sv | 55 +++++
 rtl/mem_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// rtl/mem_rr_arbiter_if.sv - consumer-side and memory-side handshake bundles for mem_rr_arbiter
// master drives requests, slave answers with ready/data.

interface mem_rr_consumer_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_request;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_request;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    modport master (
        output consumer_read_request, consumer_read_address,
        output consumer_write_request, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready
    );

    modport slave (
        input  consumer_read_request, consumer_read_address,
        input  consumer_write_request, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready
    );
endinterface

interface mem_rr_mem_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic                 mem_read_request;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_request;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_request, mem_read_address,
        output mem_write_request, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_request, mem_read_address,
        input  mem_write_request, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one memory port among NUM_CONSUMERS requesters
// Grant rotates past the served consumer after every transaction; all outputs are registered.

module mem_rr_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1,
    localparam int CID_BITS     = $clog2(NUM_CONSUMERS)
) (
    input  logic                clk,
    input  logic                reset,
    mem_rr_consumer_if.slave    cons,
    mem_rr_mem_if.master        mem,
    output logic                busy,
    output logic [CID_BITS-1:0] grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_SERVED,
        WRITE_SERVED
    } state_t;

    localparam logic WR_EN = (WRITE_ENABLE != 0);

    state_t                                  state_q, state_d;
    logic [CID_BITS-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [CID_BITS-1:0]                     grant_q, grant_d;
    logic                                    busy_q, busy_d;
    logic                                    rd_req_q, rd_req_d;
    logic [ADDR_BITS-1:0]                    rd_addr_q, rd_addr_d;
    logic                                    wr_req_q, wr_req_d;
    logic [ADDR_BITS-1:0]                    wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]                    wr_data_q, wr_data_d;
    logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic                found;
    logic                pick_read;
    logic [CID_BITS-1:0] pick_id;
    logic [CID_BITS:0]   cand;
    logic [CID_BITS:0]   grant_inc;
    logic [CID_BITS-1:0] ptr_after_grant;

    // Walk the consumers starting at rr_ptr; the first one with any eligible request wins.
    always_comb begin
        found     = 1'b0;
        pick_read = 1'b0;
        pick_id   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand = {1'b0, rr_ptr_q} + (CID_BITS+1)'(i);
            if (cand >= (CID_BITS+1)'(NUM_CONSUMERS)) begin
                cand = cand - (CID_BITS+1)'(NUM_CONSUMERS);
            end
            if (!found && (cons.consumer_read_request[cand[CID_BITS-1:0]] ||
                           (WR_EN && cons.consumer_write_request[cand[CID_BITS-1:0]]))) begin
                found     = 1'b1;
                pick_id   = cand[CID_BITS-1:0];
                pick_read = cons.consumer_read_request[cand[CID_BITS-1:0]];
            end
        end
    end

    assign grant_inc       = {1'b0, grant_q} + 1'b1;
    assign ptr_after_grant = (grant_inc == (CID_BITS+1)'(NUM_CONSUMERS)) ? '0 : grant_inc[CID_BITS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (found) state_d = pick_read ? READ_WAITING : WRITE_WAITING;
            READ_WAITING:  if (mem.mem_read_ready) state_d = READ_SERVED;
            WRITE_WAITING: if (mem.mem_write_ready) state_d = WRITE_SERVED;
            READ_SERVED:   if (!cons.consumer_read_request[grant_q]) state_d = IDLE;
            WRITE_SERVED:  if (!cons.consumer_write_request[grant_q]) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // busy is a registered copy of the current state, so it trails the state by one cycle.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        busy_d     = (state_q != IDLE);
        rd_req_d   = rd_req_q;
        rd_addr_d  = rd_addr_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_ready_d = rd_ready_q;
        wr_ready_d = wr_ready_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick_id;
                    if (pick_read) begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = cons.consumer_read_address[pick_id];
                    end else begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = cons.consumer_write_address[pick_id];
                        wr_data_d = cons.consumer_write_data[pick_id];
                    end
                end
            end
            READ_WAITING: begin
                if (mem.mem_read_ready) begin
                    rd_req_d            = 1'b0;
                    rd_data_d[grant_q]  = mem.mem_read_data;
                    rd_ready_d[grant_q] = 1'b1;
                end
            end
            WRITE_WAITING: begin
                if (mem.mem_write_ready) begin
                    wr_req_d            = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                end
            end
            READ_SERVED: begin
                if (!cons.consumer_read_request[grant_q]) begin
                    rd_ready_d[grant_q] = 1'b0;
                    rr_ptr_d            = ptr_after_grant;
                end
            end
            WRITE_SERVED: begin
                if (!cons.consumer_write_request[grant_q]) begin
                    wr_ready_d[grant_q] = 1'b0;
                    rr_ptr_d            = ptr_after_grant;
                end
            end
            default: ;
        endcase
    end

    assign busy                      = busy_q;
    assign grant_id                  = grant_q;
    assign mem.mem_read_request      = rd_req_q;
    assign mem.mem_read_address      = rd_addr_q;
    assign mem.mem_write_request     = wr_req_q;
    assign mem.mem_write_address     = wr_addr_q;
    assign mem.mem_write_data        = wr_data_q;
    assign cons.consumer_read_ready  = rd_ready_q;
    assign cons.consumer_write_ready = wr_ready_q;
    assign cons.consumer_read_data   = rd_data_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - self-checking bench for mem_rr_arbiter against a transaction-level model
module tb_mem_rr_arbiter;
    localparam int AB = 8;
    localparam int DB = 16;
    localparam int N  = 4;
    localparam int CB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    bit          c_rreq [N];
    bit          c_wreq [N];
    logic [AB-1:0] c_raddr [N];
    logic [AB-1:0] c_waddr [N];
    logic [DB-1:0] c_wdata [N];
    logic          m_rd_rdy, m_wr_rdy;
    logic [DB-1:0] m_rdata;

    bit            d_rrdy [N];
    bit            d_wrdy [N];
    bit            d_wrdy_nw [N];
    logic [DB-1:0] d_rdata [N];

    logic          busy, busy_nw;
    logic [CB-1:0] grant_id, grant_nw;

    mem_rr_consumer_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) cif();
    mem_rr_consumer_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) cif_nw();
    mem_rr_mem_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mif();
    mem_rr_mem_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mif_nw();

    for (genvar k = 0; k < N; k++) begin : g_wire
        assign cif.consumer_read_request[k]     = c_rreq[k];
        assign cif.consumer_write_request[k]    = c_wreq[k];
        assign cif.consumer_read_address[k]     = c_raddr[k];
        assign cif.consumer_write_address[k]    = c_waddr[k];
        assign cif.consumer_write_data[k]       = c_wdata[k];
        assign cif_nw.consumer_read_request[k]  = c_rreq[k];
        assign cif_nw.consumer_write_request[k] = c_wreq[k];
        assign cif_nw.consumer_read_address[k]  = c_raddr[k];
        assign cif_nw.consumer_write_address[k] = c_waddr[k];
        assign cif_nw.consumer_write_data[k]    = c_wdata[k];
        assign d_rrdy[k]    = cif.consumer_read_ready[k];
        assign d_wrdy[k]    = cif.consumer_write_ready[k];
        assign d_wrdy_nw[k] = cif_nw.consumer_write_ready[k];
        assign d_rdata[k]   = cif.consumer_read_data[k];
    end

    assign mif.mem_read_ready     = m_rd_rdy;
    assign mif.mem_read_data      = m_rdata;
    assign mif.mem_write_ready    = m_wr_rdy;
    assign mif_nw.mem_read_ready  = mif_nw.mem_read_request;
    assign mif_nw.mem_read_data   = 16'h5A5A;
    assign mif_nw.mem_write_ready = 1'b1;

    mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .cons(cif), .mem(mif), .busy(busy), .grant_id(grant_id)
    );

    mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)) dut_nw (
        .clk(clk), .reset(reset), .cons(cif_nw), .mem(mif_nw), .busy(busy_nw), .grant_id(grant_nw)
    );

    // Model: one outstanding transaction described by its phase, owner and pointer.
    typedef enum {P_IDLE, P_RD_WAIT, P_WR_WAIT, P_RD_DONE, P_WR_DONE} phase_t;
    phase_t        ph;
    int            ptr, gnt;
    bit            e_busy, e_rreq, e_wreq;
    logic [AB-1:0] e_raddr, e_waddr;
    logic [DB-1:0] e_wdata;
    bit            e_rrdy [N];
    bit            e_wrdy [N];
    logic [DB-1:0] e_rdata [N];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit keep_rd [N];
    bit rand_cons = 0, rand_mem = 0;
    int mem_wait = 0, rd_cnt = 0, wr_cnt = 0;
    bit prev_rreq = 0, prev_wreq = 0;
    int log_gnt[$], log_raddr[$], log_rcyc[$], log_rdata[$];
    int log_wgnt[$], log_waddr[$], log_wdata[$], log_wcyc[$];
    int rdy_cycles [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void model_reset();
        ph = P_IDLE; ptr = 0; gnt = 0; e_busy = 0;
        e_rreq = 0; e_wreq = 0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        for (int k = 0; k < N; k++) begin e_rrdy[k] = 0; e_wrdy[k] = 0; e_rdata[k] = '0; end
    endfunction

    function automatic void model_step();
        if (!reset) begin model_reset(); return; end
        e_busy = (ph != P_IDLE);
        case (ph)
            P_IDLE: begin
                for (int i = 0; i < N; i++) begin
                    int c = (ptr + i) % N;
                    if (c_rreq[c]) begin
                        gnt = c; e_rreq = 1; e_raddr = c_raddr[c]; ph = P_RD_WAIT; break;
                    end
                    if (c_wreq[c]) begin
                        gnt = c; e_wreq = 1; e_waddr = c_waddr[c]; e_wdata = c_wdata[c];
                        ph = P_WR_WAIT; break;
                    end
                end
            end
            P_RD_WAIT: if (m_rd_rdy) begin
                e_rreq = 0; e_rdata[gnt] = m_rdata; e_rrdy[gnt] = 1; ph = P_RD_DONE;
            end
            P_WR_WAIT: if (m_wr_rdy) begin
                e_wreq = 0; e_wrdy[gnt] = 1; ph = P_WR_DONE;
            end
            P_RD_DONE: if (!c_rreq[gnt]) begin
                e_rrdy[gnt] = 0; ptr = (gnt + 1) % N; ph = P_IDLE;
            end
            P_WR_DONE: if (!c_wreq[gnt]) begin
                e_wrdy[gnt] = 0; ptr = (gnt + 1) % N; ph = P_IDLE;
            end
            default: ;
        endcase
    endfunction

    task automatic compare_all();
        check("mem_read_request", mif.mem_read_request, e_rreq);
        check("mem_read_address", mif.mem_read_address, e_raddr);
        check("mem_write_request", mif.mem_write_request, e_wreq);
        check("mem_write_address", mif.mem_write_address, e_waddr);
        check("mem_write_data", mif.mem_write_data, e_wdata);
        check("busy", busy, e_busy);
        check("grant_id", grant_id, gnt);
        for (int k = 0; k < N; k++) begin
            check($sformatf("read_ready[%0d]", k), d_rrdy[k], e_rrdy[k]);
            check($sformatf("write_ready[%0d]", k), d_wrdy[k], e_wrdy[k]);
            check($sformatf("read_data[%0d]", k), d_rdata[k], e_rdata[k]);
            check($sformatf("nowrite_write_ready[%0d]", k), d_wrdy_nw[k], 0);
        end
        check("nowrite_mem_write_request", mif_nw.mem_write_request, 0);
        if (mif.mem_read_request && !prev_rreq) begin
            log_gnt.push_back(int'(grant_id)); log_raddr.push_back(int'(mif.mem_read_address));
            log_rcyc.push_back(cyc);
        end
        if (mif.mem_write_request && !prev_wreq) begin
            log_wgnt.push_back(int'(grant_id)); log_waddr.push_back(int'(mif.mem_write_address));
            log_wdata.push_back(int'(mif.mem_write_data)); log_wcyc.push_back(cyc);
        end
        for (int k = 0; k < N; k++) if (d_rrdy[k]) begin
            rdy_cycles[k]++; log_rdata.push_back(int'(d_rdata[k]));
        end
        prev_rreq = mif.mem_read_request;
        prev_wreq = mif.mem_write_request;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (keep_rd[k] && !c_rreq[k]) c_rreq[k] = 1;
            if (rand_cons) begin
                if (!c_rreq[k] && $urandom_range(0, 3) == 0) begin
                    c_rreq[k] = 1; c_raddr[k] = AB'($urandom);
                end
                if (!c_wreq[k] && $urandom_range(0, 3) == 0) begin
                    c_wreq[k] = 1; c_waddr[k] = AB'($urandom); c_wdata[k] = DB'($urandom);
                end
                if (c_rreq[k] && $urandom_range(0, 63) == 0) c_rreq[k] = 0;
            end
            if (c_rreq[k] && d_rrdy[k]) c_rreq[k] = 0;
            if (c_wreq[k] && d_wrdy[k]) c_wreq[k] = 0;
        end
        if (rand_mem) begin
            m_rd_rdy = ($urandom_range(0, 2) == 0);
            m_wr_rdy = ($urandom_range(0, 2) == 0);
            m_rdata  = DB'($urandom);
        end else begin
            rd_cnt   = mif.mem_read_request ? rd_cnt + 1 : 0;
            wr_cnt   = mif.mem_write_request ? wr_cnt + 1 : 0;
            m_rd_rdy = (rd_cnt > mem_wait);
            m_wr_rdy = (wr_cnt > mem_wait);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
        drive();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            bit pend = 0;
            for (int k = 0; k < N; k++) if (c_rreq[k] || c_wreq[k]) pend = 1;
            if (!pend && !busy && !mif.mem_read_request && !mif.mem_write_request) return;
            cycle();
        end
        n_total++;
        $display("FAIL idle_timeout: arbiter still busy after %0d cycles (cycle %0d)", budget, cyc);
    endtask

    task automatic clear_logs();
        log_gnt.delete(); log_raddr.delete(); log_rcyc.delete(); log_rdata.delete();
        log_wgnt.delete(); log_waddr.delete(); log_wdata.delete(); log_wcyc.delete();
        for (int k = 0; k < N; k++) rdy_cycles[k] = 0;
    endtask

    initial begin
        reset = 1'b0;
        m_rd_rdy = 0; m_wr_rdy = 0; m_rdata = '0;
        for (int k = 0; k < N; k++) begin
            c_rreq[k] = 1; c_wreq[k] = 0; keep_rd[k] = 1;
            c_raddr[k] = AB'(8'h40 + k); c_waddr[k] = '0; c_wdata[k] = '0;
            rdy_cycles[k] = 0;
        end
        model_reset();

        // Reset held with every consumer requesting, then first grant to consumer 0.
        repeat (3) cycle();
        check("reset_mem_read_request", mif.mem_read_request, 0);
        check("reset_busy", busy, 0);
        check("reset_grant_id", grant_id, 0);
        reset = 1'b1;
        mem_wait = 1;
        cycle();
        check("first_grant_id", grant_id, 0);
        check("first_grant_request", mif.mem_read_request, 1);
        check("first_grant_address", mif.mem_read_address, 8'h40);

        // Fairness with everyone requesting continuously.
        for (int i = 0; i < 200 && log_gnt.size() < 6; i++) cycle();
        for (int k = 0; k < N; k++) keep_rd[k] = 0;
        wait_idle(200);
        for (int i = 0; i < 6; i++) check($sformatf("fair_order[%0d]", i), at(log_gnt, i), i % N);

        // Single read: consumer 2, addr 0x3C, data 0xBEEF after 3 wait cycles.
        clear_logs();
        mem_wait = 3; m_rdata = 16'hBEEF;
        c_raddr[2] = 8'h3C; c_rreq[2] = 1;
        wait_idle(100);
        check("single_grant", at(log_gnt, 0), 2);
        check("single_address", at(log_raddr, 0), 8'h3C);
        check("single_data", at(log_rdata, 0), 16'hBEEF);
        check("single_ready_cycles", rdy_cycles[2], 1);

        // Pointer wrap: serve 1 (ptr->2), then 3 and 1 together, then everyone.
        clear_logs();
        mem_wait = 0;
        c_raddr[1] = 8'h11; c_rreq[1] = 1;
        wait_idle(100);
        c_rreq[3] = 1; c_rreq[1] = 1;
        wait_idle(100);
        for (int k = 0; k < N; k++) c_rreq[k] = 1;
        wait_idle(100);
        check("wrap_count", log_gnt.size(), 7);
        check("wrap_first", at(log_gnt, 1), 3);
        check("wrap_second", at(log_gnt, 2), 1);
        check("wrap_ptr_after", at(log_gnt, 3), 2);

        // Read beats write inside one consumer; write follows.
        clear_logs();
        c_raddr[1] = 8'h10; c_waddr[1] = 8'h20; c_wdata[1] = 16'h1234;
        c_rreq[1] = 1; c_wreq[1] = 1;
        wait_idle(100);
        check("rw_read_address", at(log_raddr, 0), 8'h10);
        check("rw_write_grant", at(log_wgnt, 0), 1);
        check("rw_write_address", at(log_waddr, 0), 8'h20);
        check("rw_write_data", at(log_wdata, 0), 16'h1234);
        check("rw_read_first", (at(log_rcyc, 0) >= 0) && (at(log_rcyc, 0) < at(log_wcyc, 0)), 1);

        // Mid-operation reset during READ_WAITING.
        clear_logs();
        mem_wait = 20;
        c_raddr[2] = 8'h77; c_rreq[2] = 1;
        for (int i = 0; i < 10 && !mif.mem_read_request; i++) cycle();
        check("midreset_granted", mif.mem_read_request, 1);
        cycle();
        c_raddr[1] = 8'h55; c_rreq[1] = 1;
        #2 reset = 1'b0;
        #1;
        check("midreset_async_drop", mif.mem_read_request, 0);
        model_reset();
        compare_all();
        cycle();
        cycle();
        check("midreset_no_ready", rdy_cycles[2], 0);
        reset = 1'b1;
        mem_wait = 0;
        clear_logs();
        wait_idle(100);
        check("midreset_regrant_first", at(log_gnt, 0), 1);
        check("midreset_regrant_second", at(log_gnt, 1), 2);
        check("midreset_regrant_address", at(log_raddr, 1), 8'h77);

        // Randomized traffic, random memory latency and stray ready pulses.
        rand_cons = 1; rand_mem = 1;
        repeat (3000) cycle();
        rand_cons = 0;
        wait_idle(500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
